// File: rtl/pipelined_csa.sv
// Segmented carry-select adder: NSEG stages, each resolving one SEG-bit segment
// from precomputed carry-in-0/1 candidates. `PIPELINED_CSA_SUB_EN adds a sub port.
module pipelined_csa #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef PIPELINED_CSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int NSEG = WIDTH / SEG;

  // Every stage carries all segment candidates; stage k consumes slot k.
  typedef struct packed {
    logic [NSEG-1:0][SEG:0] c0;
    logic [NSEG-1:0][SEG:0] c1;
    logic [WIDTH-1:0]       sum;
    logic                   cy;
    logic                   sa;
    logic                   sb;
  } stage_t;

  stage_t [NSEG-1:0] st_q, st_d;
  logic   [NSEG-1:0] vld_q, vld_d;
  stage_t            ent;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic              advance;

`ifdef PIPELINED_CSA_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = c_in ^ sub;
`else
  assign b_eff   = b;
  assign cin_eff = c_in;
`endif

  always_comb begin
    ent = '0;
    for (int s = 0; s < NSEG; s++) begin
      ent.c0[s] = {1'b0, a[s*SEG +: SEG]} + {1'b0, b_eff[s*SEG +: SEG]};
      ent.c1[s] = ent.c0[s] + (SEG+1)'(1);
    end
    ent.sum[SEG-1:0] = cin_eff ? ent.c1[0][SEG-1:0] : ent.c0[0][SEG-1:0];
    ent.cy           = cin_eff ? ent.c1[0][SEG]     : ent.c0[0][SEG];
    ent.sa           = a[WIDTH-1];
    ent.sb           = b_eff[WIDTH-1];
  end

  assign advance  = !vld_q[NSEG-1] || out_ready;
  assign in_ready = advance;

  always_comb begin
    st_d  = st_q;
    vld_d = vld_q;
    if (advance) begin
      st_d[0]  = ent;
      vld_d[0] = in_valid;
      for (int k = 1; k < NSEG; k++) begin
        st_d[k] = st_q[k-1];
        st_d[k].sum[k*SEG +: SEG] = st_q[k-1].cy ? st_q[k-1].c1[k][SEG-1:0]
                                                 : st_q[k-1].c0[k][SEG-1:0];
        st_d[k].cy = st_q[k-1].cy ? st_q[k-1].c1[k][SEG] : st_q[k-1].c0[k][SEG];
        vld_d[k]   = vld_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= '0;
      vld_q <= '0;
    end else begin
      st_q  <= st_d;
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q[NSEG-1];
  assign sum       = st_q[NSEG-1].sum;
  assign c_out     = st_q[NSEG-1].cy;
  assign ovf       = (st_q[NSEG-1].sa == st_q[NSEG-1].sb) &&
                     (st_q[NSEG-1].sum[WIDTH-1] != st_q[NSEG-1].sa);
endmodule

// File: tb/tb_pipelined_csa.sv
// Random + directed bench for pipelined_csa against a plain-arithmetic scoreboard.
module tb_pipelined_csa;
  localparam int W = 64;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0, c_in = 1'b0, sub_i = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, c_out, ovf;
  logic [W-1:0] sum;

  int n_cmp = 0, n_err = 0, n_out = 0;
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_csa #(.WIDTH(W), .SEG(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
`ifdef PIPELINED_CSA_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ovf, c_out, sum} of x + y + ci (subtract: x + ~y + !ci)
  function automatic logic [W+1:0] model(input logic [W-1:0] x, y, input logic ci, s);
    logic [W-1:0] ye;
    logic [W:0]   r;
    ye = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ci ^ s};
    return {(x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]), r};
  endfunction

  function automatic logic rsub();
`ifdef PIPELINED_CSA_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] rop();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '1;
      1: v = {1'b0, {(W-1){1'b1}}};
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = W'($urandom_range(0, 3));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Scoreboard: sampled 1ns before each rising edge.
  always @(negedge clk) begin
    #4;
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub_i));
      if (out_valid && out_ready) begin
        n_out++;
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("sb_result", {ovf, c_out, sum}, exp_q.pop_front());
      end
    end
  end

  task automatic run_one(input logic [W-1:0] x, y, input logic ci, s,
                         output logic [W+1:0] r, output int lat);
    bit got_v = 1'b0;
    @(negedge clk);
    a = x; b = y; c_in = ci; sub_i = s; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; lat = 0; r = '0;
    for (int i = 0; i < 20 && !got_v; i++) begin
      #1;
      lat++;
      if (out_valid) begin
        got_v = 1'b1;
        r = {ovf, c_out, sum};
      end else @(negedge clk);
    end
    chk("run_one_timeout", got_v, 1);
  endtask

  initial begin
    logic [W+1:0] r, hold;
    logic [W-1:0] got_s[$];
    int lat, first, last, n0;

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout_ovf", {c_out, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_one('1, '0, 1'b1, 1'b0, r, lat);
    chk("allones_res", r, {1'b0, 1'b1, 64'h0});
    chk("allones_lat", lat, 4);

    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, r, lat);
    chk("ovf_res", r, {1'b1, 1'b0, 64'h8000_0000_0000_0000});

`ifdef PIPELINED_CSA_SUB_EN
    run_one(64'd5, 64'd7, 1'b0, 1'b1, r, lat);
    chk("sub_res", r, {2'b00, 64'hFFFF_FFFF_FFFF_FFFE});
`else
    run_one(64'd5, 64'd7, 1'b0, 1'b0, r, lat);
    chk("add_res", r, {2'b00, 64'd12});
`endif

    // back-to-back accepts
    first = -1; last = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      out_ready = 1'b1; sub_i = 1'b0;
      if (i < 3) begin
        in_valid = 1'b1; a = W'(i + 1); b = 64'd10; c_in = 1'b0;
      end else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        got_s.push_back(sum);
      end
    end
    chk("b2b_count", got_s.size(), 3);
    chk("b2b_first", first, 4);
    chk("b2b_consec", last - first, 2);
    for (int j = 0; j < got_s.size() && j < 3; j++) chk("b2b_sum", got_s[j], 64'd11 + 64'(j));

    // stall with a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = rop(); b = rop(); c_in = 1'($urandom_range(0, 1)); sub_i = rsub();
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    hold = {ovf, c_out, sum};
    n0 = n_out;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_hold", {ovf, c_out, sum}, hold);
    end
    @(negedge clk);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("stall_drain", n_out - n0, 4);

    // asynchronous reset with work in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = rop(); b = rop(); c_in = 1'($urandom_range(0, 1)); sub_i = rsub();
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_data", {ovf, c_out, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_out;
    repeat (6) @(negedge clk);
    chk("rst_no_ghost", n_out - n0, 0);
    run_one(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, r, lat);
    chk("post_rst_res", r, {1'b0, 1'b1, 64'h0});
    chk("post_rst_lat", lat, 4);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = rop(); b = rop(); c_in = 1'($urandom_range(0, 1)); sub_i = rsub();
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_csa.md
PIPELINED_CSA -- requirements
Module: pipelined_csa

Interface
REQ-001 Parameter WIDTH, default 64, operand and sum width in bits.
REQ-002 Parameter SEG, default 16, segment width in bits; WIDTH % SEG == 0 and SEG >= 1 SHALL hold; NSEG = WIDTH/SEG.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands a, b, c_in are valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH  addend operands.
REQ-008 c_in  input  1  carry into bit 0.
REQ-009 out_valid  output  1  sum, c_out and ovf are valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 sum  output  WIDTH  result bits [WIDTH-1:0].
REQ-012 c_out  output  1  carry out of bit WIDTH-1.
REQ-013 ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-014 Block SHALL be an NSEG-stage pipeline; stage k SHALL resolve segment k by selecting between two precomputed segment sums (carry-in 0 and carry-in 1) using the registered carry from segment k-1.
REQ-015 Segment 0 SHALL use c_in as its select; both candidate sums for every segment SHALL be computed at acceptance and carried down the pipeline with the operand segments.
REQ-016 Transfer in SHALL occur on a rising edge when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 advance = !out_valid || out_ready; in_ready SHALL equal advance combinationally; all stages SHALL shift together only when advance is 1.
REQ-018 Latency: result of an operation accepted on edge t SHALL appear on outputs after edge t+NSEG-1 with no stall; NSEG=1 gives result right after the accepting edge.
REQ-019 Throughput SHALL be one operation per cycle while out_ready=1; results SHALL leave in acceptance order.
REQ-020 Each stage SHALL hold a valid bit; empty slots (bubbles) SHALL propagate with valid=0 and SHALL never produce out_valid.
REQ-021 While out_valid=1 and out_ready=0, sum, c_out, ovf SHALL hold stable and no stage SHALL change.
REQ-022 sum/c_out SHALL equal the (WIDTH+1)-bit result of a + b + c_in; no truncation beyond WIDTH plus c_out.
REQ-023 ovf SHALL be 1 iff the operand sign bits (post-inversion when subtracting) are equal and sum[WIDTH-1] differs from them.
REQ-024 in_valid=0 on an advancing edge SHALL insert a bubble; simultaneous accept and deliver on one edge SHALL both take effect.

Reset
REQ-025 rst_n=0 SHALL immediately clear every stage valid bit, making out_valid=0 without waiting for clk.
REQ-026 During reset, sum=0, c_out=0, ovf=0 and all pipeline data registers SHALL be 0; in_ready SHALL read 1.
REQ-027 Operations in flight when reset asserts SHALL be discarded; none SHALL emerge after rst_n returns to 1.

Configuration
REQ-028 Macro PIPELINED_CSA_SUB_EN defined: an input port sub (1 bit, sampled with a/b) SHALL exist; sub=1 SHALL compute a + ~b + (c_in ^ 1), sub=0 SHALL compute a + b + c_in.
REQ-029 Macro undefined: port sub SHALL be absent and the block SHALL only add; no inversion logic SHALL be synthesized.

Verification (WIDTH=64, SEG=16, NSEG=4)
REQ-030 a=0xFFFF_FFFF_FFFF_FFFF, b=0, c_in=1, out_ready=1 -> sum=0, c_out=1, ovf=0, out_valid high after 4th edge counting the accept edge.
REQ-031 Three back-to-back accepts (a=1,2,3; b=10; c_in=0), out_ready=1 -> sums 11,12,13 on three consecutive cycles, in order.
REQ-032 Pipeline full, out_ready=0 for 5 cycles -> in_ready=0, outputs stable all 5 cycles; on out_ready=1 remaining results drain one per cycle, none lost or duplicated.
REQ-033 Two ops in flight, rst_n pulsed low mid-cycle -> out_valid=0 asynchronously, no result appears after release, next op returns correct sum with full latency.
REQ-034 a=0x7FFF_FFFF_FFFF_FFFF, b=1, c_in=0 -> sum=0x8000_0000_0000_0000, c_out=0, ovf=1.
REQ-035 With PIPELINED_CSA_SUB_EN: sub=1, a=5, b=7, c_in=0 -> sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0, ovf=0; same vector without the macro and b=7 -> sum=12.
